// File: rtl/ps2_key_encoder_if.sv
// Pin-side bundle for ps2_key_encoder: raw PS/2 lines in, key event word and status out.
// Events carry no valid/ready pair: a consumer sees a new key event whenever ps2_key[10] changes, and the word holds until the next event.
interface ps2_key_encoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (output ps2_clk, ps2_data, input ps2_key, frame_err, busy);
    modport slave  (input ps2_clk, ps2_data, output ps2_key, frame_err, busy);
endinterface

// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 deframer and prefix decoder producing the 11-bit toggle-strobed key event word.
// Optional macro PS2_PAUSE_KEY_EN: the E1 Pause sequence emits one extended 0x77 press event.
module ps2_key_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT     = 24000
) (
    input  logic              clk_sys,
    input  logic              reset,
    ps2_key_encoder_if.slave  bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
`ifdef PS2_PAUSE_KEY_EN
    localparam bit PAUSE_EVENT = 1'b1;
`else
    localparam bit PAUSE_EVENT = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE
    } dec_state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_s, data_s;
    logic                   filt_q;
    logic [FCW-1:0]         filt_cnt_q;
    logic                   filt_flip, sample_edge;
    logic [3:0]             bit_cnt_q;
    logic [9:0]             shift_q;
    logic [TCW-1:0]         tmo_cnt_q;
    logic                   busy, stop_edge, frame_ok, byte_stb, frame_bad, timeout;
    logic                   err_q;
    logic [7:0]             rx_byte;
    dec_state_e             state_q, state_d;
    logic [2:0]             skip_q, skip_d;
    logic [10:0]            key_q;
    logic                   emit, emit_ext, emit_brk;
    logic [7:0]             emit_code;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
        end
    end

    // The filtered clock only flips after FILTER_LEN consecutive opposite samples.
    assign filt_flip   = (clk_s != filt_q) && (filt_cnt_q == FCW'(FILTER_LEN - 1));
    assign sample_edge = filt_flip && filt_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s != filt_q) begin
            if (filt_flip) begin
                filt_q     <= ~filt_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_q <= '0;
        end
    end

    // After ten shifts: [0]=start, [8:1]=d0..d7, [9]=parity; the stop bit is read live.
    assign busy      = (bit_cnt_q != 4'd0);
    assign stop_edge = sample_edge && (bit_cnt_q == 4'd10);
    assign frame_ok  = ~shift_q[0] & data_s & (^shift_q[9:1]);
    assign byte_stb  = stop_edge & frame_ok;
    assign frame_bad = stop_edge & ~frame_ok;
    assign timeout   = busy && !sample_edge && (tmo_cnt_q == TCW'(TIMEOUT - 1));
    assign rx_byte   = shift_q[8:1];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= frame_bad | timeout;
            if (sample_edge) begin
                tmo_cnt_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    shift_q   <= {data_s, shift_q[9:1]};
                end
            end else if (timeout) begin
                bit_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end else if (busy) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        emit_code = rx_byte;
        if (frame_bad || timeout) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
        end else if (byte_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == 8'hE0)      state_d = ST_EXT;
                    else if (rx_byte == 8'hF0) state_d = ST_BRK;
                    else if (rx_byte == 8'hE1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end else if (rx_byte != 8'h00 && rx_byte != 8'hFF) emit = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == 8'hF0)      state_d = ST_EXT_BRK;
                    else if (rx_byte != 8'hE0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (rx_byte == 8'hE0)      state_d = ST_EXT_BRK;
                    else if (rx_byte != 8'hF0) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d   = ST_IDLE;
                        emit      = PAUSE_EVENT;
                        emit_ext  = 1'b1;
                        emit_code = 8'h77;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            key_q   <= 11'h000;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            if (emit) key_q <= {~key_q[10], ~emit_brk, emit_ext, emit_code};
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy;
endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Receives the raw PS/2 keyboard serial line (clock + data) and deframes set-2 scancode bytes.
- Folds E0/F0/E1 prefixes into single key events.
- Emits the 11-bit ps2_key event word that core-level keyboard mappers consume: [10] toggle strobe, [9] pressed, [8] extended, [7:0] code.
- Sits between the physical PS/2 pins and any core input mapper, so a core can run from a real keyboard instead of the HPS-supplied word.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data.
- FILTER_LEN, 8: consecutive identical clk_sys samples required to change the filtered ps2_clk level.
- TIMEOUT, 24000: clk_sys cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 12 MHz).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ps2_key  out  11  event word: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- frame_err  out  1  one-cycle pulse on a bad or timed-out frame.
- busy  out  1  high while a frame is partially received (bit count != 0).

Behaviour:
- Reset values: ps2_key=11'h000, frame_err=0, busy=0. Bit counter=0, decoder=IDLE, timeout counter=0.
- reset dominates every simultaneous event.
- Reset mid-frame or mid-sequence discards all partial state; no event is emitted.
- Input conditioning:
  - Both inputs pass SYNC_STAGES flops.
  - Filtered clock starts at 1 and flips only after FILTER_LEN consecutive samples at the opposite level.
  - A filtered 1->0 transition is a sample edge; data is taken from the synchronised ps2_data on that cycle.
- Frame: 11 bits = start(0), d0..d7 LSB first, odd parity, stop(1). Bit counter runs 0..10 and wraps to 0 after stop.
- Frame check on the stop edge:
  - start==0, stop==1 and XOR(d7..d0, parity)==1: internal byte strobe fires on that cycle.
  - Otherwise: frame_err pulses the next cycle, the byte is dropped and the decoder returns to IDLE.
- Timeout: while busy, TIMEOUT cycles without a sample edge clear the bit counter, pulse frame_err and return the decoder to IDLE.
- Decoder FSM, one transition per byte strobe:
  - IDLE: E0 -> EXT. F0 -> BRK. E1 -> PAUSE (skip count=7). 00 or FF (overrun) -> discarded, stay IDLE. Any other byte -> emit(ext=0, brk=0), stay IDLE.
  - EXT: F0 -> EXT_BRK. E0 -> stay EXT. Other byte -> emit(ext=1, brk=0) -> IDLE.
  - BRK: E0 -> EXT_BRK. F0 -> stay BRK. Other byte -> emit(ext=0, brk=1) -> IDLE.
  - EXT_BRK: F0/E0 -> stay. Other byte -> emit(ext=1, brk=1) -> IDLE.
  - PAUSE: decrement the skip count per byte. When the count reaches 0 -> IDLE (optional event, see below).
- emit: on the clock after the byte strobe, all of the following update on the same edge:
  - ps2_key[7:0] <= byte
  - ps2_key[8] <= ext
  - ps2_key[9] <= ~brk
  - ps2_key[10] <= ~ps2_key[10]
- Between emits ps2_key holds its value. Consumers detect events by [10] changing.
- Latency: emit occurs at most SYNC_STAGES+FILTER_LEN+2 clk_sys after the raw ps2_clk falling edge of the stop bit.
- Back-to-back frames need no gap. Each byte is fully handled before the next sample edge, since FILTER_LEN >= 2 guarantees spacing.
- Glitches shorter than FILTER_LEN cycles on ps2_clk never produce a sample edge.

Optional Feature:
- PS2_PAUSE_KEY_EN defined: when the PAUSE skip count reaches 0, emit one event with code 8'h77, ext=1, pressed=1, and toggle [10].
  - Pause has no break event.
  - A frame error inside the sequence aborts it with no event.
- Not defined: the complete E1 sequence (E1 14 77 E1 F0 14 F0 77) is swallowed silently and ps2_key is unchanged.

Test Plan:
1. Send byte 1C, half-bit 40 clk_sys, FILTER_LEN=8 -> one toggle; ps2_key[9:0]=10'h21C (pressed, non-ext).
2. Send F0 then 1C -> one toggle only; ps2_key[9:0]=10'h01C. Then send E0 F0 75 -> one further toggle; ps2_key[9:0]=10'h175.
3. Send 29 with a wrong parity bit -> frame_err pulse of 1 cycle, no toggle. Then a clean E0 75 -> ps2_key[9:0]=10'h375, proving the decoder was reset to IDLE.
4. Stop after 5 bits, idle 24000+ cycles -> frame_err pulse, busy falls to 0. Then a clean 16 -> ps2_key[7:0]=8'h16.
5. Send the full E1 pause sequence:
   - With PS2_PAUSE_KEY_EN: exactly one toggle, ps2_key[9:0]=10'h377.
   - Without it: zero toggles.
   - A following 1E yields ps2_key[9:0]=10'h21E in both cases.
6. Assert reset after bit 6 of byte 5A, then send a full 5A -> no partial event; exactly one toggle with ps2_key[9:0]=10'h25A. Also inject 3-cycle ps2_clk glitches during idle -> no frame activity (busy stays 0).
